// File: rtl/dispatch_alloc_pkg.sv
// Shared sizes, index/pointer types and stall-cause encoding for the dispatch allocator.
package dispatch_alloc_pkg;

  localparam int WIDTH          = 3;
  localparam int RS_SIZE        = 16;
  localparam int LQ_SIZE        = 8;
  localparam int SQ_SIZE        = 8;
  localparam int REL_PORTS      = 2;

  localparam int DISPATCH_WIDTH = WIDTH;
  localparam int CNT_W          = $clog2(WIDTH + 1);
  localparam int RS_IDX_W       = $clog2(RS_SIZE);
  localparam int LQ_IDX_W       = $clog2(LQ_SIZE);
  localparam int SQ_IDX_W       = $clog2(SQ_SIZE);

  // Running sums must hold the largest queue's full free count.
  localparam int MAX_SIZE = (RS_SIZE > LQ_SIZE) ?
                            ((RS_SIZE > SQ_SIZE) ? RS_SIZE : SQ_SIZE) :
                            ((LQ_SIZE > SQ_SIZE) ? LQ_SIZE : SQ_SIZE);
  localparam int SUM_W    = $clog2(MAX_SIZE) + 1;

  typedef logic [RS_IDX_W-1:0] rs_idx_t;
  typedef logic [LQ_IDX_W-1:0] lq_idx_t;
  typedef logic [SQ_IDX_W-1:0] sq_idx_t;

  typedef struct packed {
    logic    wrap;
    lq_idx_t idx;
  } lq_ptr_t;

  typedef struct packed {
    logic    wrap;
    sq_idx_t idx;
  } sq_ptr_t;

  localparam int STALL_RS  = 0;
  localparam int STALL_LQ  = 1;
  localparam int STALL_SQ  = 2;
  localparam int STALL_ROB = 3;

  // One-hot blocking cause for a lane that failed at least one resource check.
  function automatic logic [3:0] stall_vec(input logic rob_ok, input logic sq_ok,
                                           input logic lq_ok);
    logic [3:0] v;
    v = '0;
    if (!rob_ok)      v[STALL_ROB] = 1'b1;
    else if (!sq_ok)  v[STALL_SQ]  = 1'b1;
    else if (!lq_ok)  v[STALL_LQ]  = 1'b1;
    else              v[STALL_RS]  = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/queue_ptr_ring.sv
// Head/tail pointer pair with wrap bits for a circular load or store queue.
module queue_ptr_ring
  import dispatch_alloc_pkg::*;
#(
  parameter int  SIZE  = LQ_SIZE,
  parameter type ptr_t = lq_ptr_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [CNT_W-1:0]         alloc_cnt,
  input  logic [CNT_W-1:0]         commit_cnt,
  output logic [$clog2(SIZE)-1:0]  tail_idx,
  output logic [$clog2(SIZE):0]    free_cnt
);

  localparam int IDX_W = $clog2(SIZE);

  ptr_t             head;
  ptr_t             tail;
  logic [IDX_W:0]   head_v;
  logic [IDX_W:0]   tail_v;
  logic [IDX_W:0]   count;
  logic [IDX_W:0]   head_next;

  assign head_v    = head;
  assign tail_v    = tail;
  assign count     = tail_v - head_v;
  assign free_cnt  = (IDX_W+1)'(SIZE) - count;
  assign head_next = head_v + (IDX_W+1)'(commit_cnt);
  assign tail_idx  = tail.idx;

  // A flush discards every uncommitted entry, so the tail snaps to the new head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= ptr_t'(head_next);
      tail <= flush ? ptr_t'(head_next) : ptr_t'(tail_v + (IDX_W+1)'(alloc_cnt));
    end
  end

  commit_within_occupancy: assert property (
    @(posedge clock) disable iff (reset) (IDX_W+1)'(commit_cnt) <= count);

endmodule

// File: rtl/rs_free_pick.sv
// Finds the DISPATCH_WIDTH lowest free reservation-station entries with a
// chain of priority encoders, each masking out the previous winner.
module rs_free_pick
  import dispatch_alloc_pkg::*;
(
  input  logic [RS_SIZE-1:0]                 free_map,
  output logic [DISPATCH_WIDTH*RS_IDX_W-1:0] pick_idx,
  output logic [DISPATCH_WIDTH-1:0]          pick_valid
);

  logic [RS_SIZE-1:0] mask;

  always_comb begin
    mask       = free_map;
    pick_idx   = '0;
    pick_valid = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      // Descending scan so the last hit is the lowest set bit.
      for (int j = RS_SIZE - 1; j >= 0; j--) begin
        if (mask[j]) begin
          pick_valid[k]                        = 1'b1;
          pick_idx[k*RS_IDX_W +: RS_IDX_W]     = rs_idx_t'(j);
        end
      end
      if (pick_valid[k]) begin
        mask[pick_idx[k*RS_IDX_W +: RS_IDX_W]] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dispatch_alloc.sv
// Dispatch-stage allocator: grants an in-order prefix of lanes and hands out
// RS, LQ and SQ slots, gated by ROB space.
module dispatch_alloc
  import dispatch_alloc_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [DISPATCH_WIDTH-1:0]           in_valid,
  input  logic [DISPATCH_WIDTH-1:0]           in_is_load,
  input  logic [DISPATCH_WIDTH-1:0]           in_is_store,
  input  logic [CNT_W-1:0]                    rob_free_cnt,
  input  logic [REL_PORTS-1:0]                rel_valid,
  input  logic [REL_PORTS*RS_IDX_W-1:0]       rel_idx,
  input  logic [CNT_W-1:0]                    lq_commit_cnt,
  input  logic [CNT_W-1:0]                    sq_commit_cnt,
  output logic [DISPATCH_WIDTH-1:0]           out_fire,
  output logic [DISPATCH_WIDTH*RS_IDX_W-1:0]  out_rs_idx,
  output logic [DISPATCH_WIDTH*LQ_IDX_W-1:0]  out_lq_idx,
  output logic [DISPATCH_WIDTH*SQ_IDX_W-1:0]  out_sq_idx,
  output logic [CNT_W-1:0]                    out_cnt,
  output logic [3:0]                          stall_cause
);

  logic [RS_SIZE-1:0]                 rs_free;
  logic [DISPATCH_WIDTH*RS_IDX_W-1:0] pick_idx;
  logic [DISPATCH_WIDTH-1:0]          pick_valid;

  lq_idx_t                            lq_tail_idx;
  sq_idx_t                            sq_tail_idx;
  logic [LQ_IDX_W:0]                  lq_free;
  logic [SQ_IDX_W:0]                  sq_free;

  logic [DISPATCH_WIDTH-1:0]          fire;
  logic [DISPATCH_WIDTH*RS_IDX_W-1:0] rs_flat;
  logic [DISPATCH_WIDTH*LQ_IDX_W-1:0] lq_flat;
  logic [DISPATCH_WIDTH*SQ_IDX_W-1:0] sq_flat;
  logic [3:0]                         stall;
  logic [CNT_W-1:0]                   fire_cnt;
  logic [CNT_W-1:0]                   lq_alloc_cnt;
  logic [CNT_W-1:0]                   sq_alloc_cnt;
  logic [RS_SIZE-1:0]                 alloc_mask;
  logic [RS_SIZE-1:0]                 rel_mask;

  logic                               blocked;
  logic                               rob_ok;
  logic                               rs_ok;
  logic                               lq_ok;
  logic                               sq_ok;
  logic [SUM_W-1:0]                   fire_sum;
  logic [SUM_W-1:0]                   ld_sum;
  logic [SUM_W-1:0]                   st_sum;
  rs_idx_t                            lane_rs;

  rs_free_pick u_pick (
    .free_map   (rs_free),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  queue_ptr_ring #(.SIZE(LQ_SIZE), .ptr_t(lq_ptr_t)) u_lq_ring (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .alloc_cnt  (lq_alloc_cnt),
    .commit_cnt (lq_commit_cnt),
    .tail_idx   (lq_tail_idx),
    .free_cnt   (lq_free)
  );

  queue_ptr_ring #(.SIZE(SQ_SIZE), .ptr_t(sq_ptr_t)) u_sq_ring (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .alloc_cnt  (sq_alloc_cnt),
    .commit_cnt (sq_commit_cnt),
    .tail_idx   (sq_tail_idx),
    .free_cnt   (sq_free)
  );

  // Walk lanes in order with running resource sums; the first valid lane that
  // does not fit latches the stall cause and shadows every later lane.
  always_comb begin
    fire       = '0;
    rs_flat    = '0;
    lq_flat    = '0;
    sq_flat    = '0;
    stall      = '0;
    alloc_mask = '0;
    blocked    = 1'b0;
    fire_sum   = '0;
    ld_sum     = '0;
    st_sum     = '0;
    rob_ok     = 1'b0;
    rs_ok      = 1'b0;
    lq_ok      = 1'b0;
    sq_ok      = 1'b0;
    lane_rs    = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      rob_ok  = (fire_sum + SUM_W'(1)) <= SUM_W'(rob_free_cnt);
      lq_ok   = (ld_sum + SUM_W'(in_is_load[i])) <= SUM_W'(lq_free);
      sq_ok   = (st_sum + SUM_W'(in_is_store[i])) <= SUM_W'(sq_free);
      rs_ok   = pick_valid[fire_sum[CNT_W-1:0]];
      lane_rs = pick_idx[fire_sum[CNT_W-1:0]*RS_IDX_W +: RS_IDX_W];
      if (in_valid[i] && !blocked && !flush) begin
        if (rob_ok && rs_ok && lq_ok && sq_ok) begin
          fire[i]                              = 1'b1;
          rs_flat[i*RS_IDX_W +: RS_IDX_W]      = lane_rs;
          alloc_mask[lane_rs]                  = 1'b1;
          if (in_is_load[i]) begin
            lq_flat[i*LQ_IDX_W +: LQ_IDX_W]    = lq_tail_idx + LQ_IDX_W'(ld_sum);
            ld_sum                             = ld_sum + SUM_W'(1);
          end
          if (in_is_store[i]) begin
            sq_flat[i*SQ_IDX_W +: SQ_IDX_W]    = sq_tail_idx + SQ_IDX_W'(st_sum);
            st_sum                             = st_sum + SUM_W'(1);
          end
          fire_sum = fire_sum + SUM_W'(1);
        end else begin
          blocked = 1'b1;
          stall   = stall_vec(rob_ok, sq_ok, lq_ok);
        end
      end
    end
    fire_cnt     = CNT_W'(fire_sum);
    lq_alloc_cnt = CNT_W'(ld_sum);
    sq_alloc_cnt = CNT_W'(st_sum);
  end

  always_comb begin
    rel_mask = '0;
    for (int p = 0; p < REL_PORTS; p++) begin
      if (rel_valid[p]) begin
        rel_mask[rel_idx[p*RS_IDX_W +: RS_IDX_W]] = 1'b1;
      end
    end
  end

  // Releases land at the same edge as allocations, so a freed entry is only
  // visible to the picker from the next cycle on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rs_free <= '1;
    end else if (flush) begin
      rs_free <= '1;
    end else begin
      rs_free <= (rs_free & ~alloc_mask) | rel_mask;
    end
  end

  assign out_fire    = reset ? '0 : fire;
  assign out_rs_idx  = reset ? '0 : rs_flat;
  assign out_lq_idx  = reset ? '0 : lq_flat;
  assign out_sq_idx  = reset ? '0 : sq_flat;
  assign out_cnt     = reset ? '0 : fire_cnt;
  assign stall_cause = reset ? '0 : stall;

  no_load_and_store: assert property (
    @(posedge clock) disable iff (reset) (in_valid & in_is_load & in_is_store) == '0);

  no_release_of_free: assert property (
    @(posedge clock) disable iff (reset) flush || ((rel_mask & rs_free) == '0));

endmodule
